// File: rtl/axi_lite_regfile_strb.sv
// AXI4-Lite slave register file with byte strobes, independent AW/W buffering,
// per-register read-only masking and SLVERR on illegal accesses.
module axi_lite_regfile_strb #(
  parameter int unsigned         ADDR_WIDTH = 8,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rvalid_o,
  input  logic                    rready_i
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffsW = $clog2(StrbW);
  localparam int unsigned IdxW  = ADDR_WIDTH - OffsW;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_full_q, aw_full_d;
  logic [IdxW-1:0]       aw_idx_q, aw_idx_d;
  logic                  w_full_q, w_full_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
  logic [StrbW-1:0]      w_strb_q, w_strb_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic            aw_hs, w_hs, ar_hs, commit, wr_ok;
  logic [IdxW-1:0] ar_idx;

  // Ready signals depend only on state, never on the matching VALID.
  assign awready_o = !reset_i && !aw_full_q && !bvalid_q;
  assign wready_o  = !reset_i && !w_full_q && !bvalid_q;
  assign arready_o = !reset_i && !rvalid_q;

  assign aw_hs  = awvalid_i && awready_o;
  assign w_hs   = wvalid_i && wready_o;
  assign ar_hs  = arvalid_i && arready_o;
  assign ar_idx = araddr_i[ADDR_WIDTH-1:OffsW];
  assign commit = aw_full_q && w_full_q && !bvalid_q;

  assign bvalid_o = bvalid_q;
  assign bresp_o  = bresp_q;
  assign rvalid_o = rvalid_q;
  assign rresp_o  = rresp_q;
  assign rdata_o  = rdata_q;

  // Write path: buffer AW/W independently, commit strobed bytes when both are held.
  always_comb begin
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    wr_ok     = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx_q == IdxW'(i) && !RO_MASK[i]) wr_ok = 1'b1;
    end
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = awaddr_i[ADDR_WIDTH-1:OffsW];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      w_data_d = wdata_i;
      w_strb_d = wstrb_i;
    end
    if (commit) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_ok ? RespOkay : RespSlvErr;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && aw_idx_q == IdxW'(i)) begin
          for (int k = 0; k < StrbW; k++) begin
            if (w_strb_q[k]) regs_d[i][8*k +: 8] = w_data_q[8*k +: 8];
          end
        end
      end
    end
    if (bvalid_q && bready_i) bvalid_d = 1'b0;
  end

  // Read path: capture the pre-commit register value on the AR handshake.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RespSlvErr;
      rdata_d  = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ar_idx == IdxW'(i)) begin
          rresp_d = RespOkay;
          rdata_d = regs_q[i];
        end
      end
    end else if (rvalid_q && rready_i) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset discards buffered requests and pending responses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      regs_q    <= '{default: '0};
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      regs_q    <= regs_d;
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile_strb.sv
// Scoreboard bench for axi_lite_regfile_strb (register 2 configured read-only).
module tb_axi_lite_regfile_strb;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [7:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [16];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  always #5 clk = ~clk;

  axi_lite_regfile_strb #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .NUM_REGS  (16),
    .RO_MASK   (16'h0004)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .awaddr_i (awaddr),
    .awvalid_i(awvalid),
    .awready_o(awready),
    .wdata_i  (wdata),
    .wstrb_i  (wstrb),
    .wvalid_i (wvalid),
    .wready_o (wready),
    .bresp_o  (bresp),
    .bvalid_o (bvalid),
    .bready_i (bready),
    .araddr_i (araddr),
    .arvalid_i(arvalid),
    .arready_o(arready),
    .rdata_o  (rdata),
    .rresp_o  (rresp),
    .rvalid_o (rvalid),
    .rready_i (rready)
  );

  task automatic send_aw(input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL aw_timeout got awready=%b want 1", awready); end
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(negedge clk);
    wdata = d; wstrb = s; wvalid = 1'b1;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL w_timeout got wready=%b want 1", wready); end
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [7:0] a);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL ar_timeout got arready=%b want 1", arready); end
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  // Update the model and queue the expected response, then drive AW/W.
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int lead);
    int idx;
    idx = int'(a[7:2]);
    if (idx < 16 && idx != 2) begin
      for (int k = 0; k < 4; k++) if (s[k]) mem[idx][8*k +: 8] = d[8*k +: 8];
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
    if (lead == 0) begin
      fork
        send_aw(a);
        send_w(d, s);
      join
    end else begin
      fork
        send_w(d, s);
        begin repeat (lead) @(negedge clk); send_aw(a); end
      join
    end
  endtask

  task automatic rd(input logic [7:0] a);
    int idx;
    idx = int'(a[7:2]);
    if (idx < 16) rq.push_back({2'b00, mem[idx]});
    else rq.push_back({2'b10, 32'h0});
    send_ar(a);
  endtask

  task automatic get_b(input int hold);
    int n = 0;
    logic [1:0] exp;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!bvalid) begin errors++; $display("FAIL b_timeout got bvalid=%b want 1", bvalid); end
    exp = (bq.size() > 0) ? bq.pop_front() : 2'bxx;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({bvalid, bresp, awready, wready} !== {1'b1, exp, 2'b00}) begin
        errors++;
        $display("FAIL b_hold got v=%b resp=%b awr=%b wr=%b want v=1 resp=%b rdy=00",
                 bvalid, bresp, awready, wready, exp);
      end
    end
    checks++;
    if (bresp !== exp) begin errors++; $display("FAIL bresp got %b want %b", bresp, exp); end
    @(negedge clk); bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
    checks++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL b_release got v=%b awr=%b wr=%b want v=0 rdy=11", bvalid, awready, wready);
    end
  endtask

  task automatic get_r(input int hold);
    int n = 0;
    logic [33:0] exp;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!rvalid) begin errors++; $display("FAIL r_timeout got rvalid=%b want 1", rvalid); end
    exp = (rq.size() > 0) ? rq.pop_front() : 34'hx;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({rvalid, rresp, rdata, arready} !== {1'b1, exp, 1'b0}) begin
        errors++;
        $display("FAIL r_hold got v=%b resp=%b data=%h arr=%b want resp/data=%h arr=0",
                 rvalid, rresp, rdata, arready, exp);
      end
    end
    checks++;
    if ({rresp, rdata} !== exp) begin
      errors++;
      $display("FAIL rdata got resp=%b data=%h want %h", rresp, rdata, exp);
    end
    @(negedge clk); rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      errors++;
      $display("FAIL r_release got v=%b arr=%b want v=0 arr=1", rvalid, arready);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b%b%b bv=%b rv=%b data=%h want all 0",
               awready, wready, arready, bvalid, rvalid, rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({awready, wready, arready} !== 3'b111) begin
      errors++;
      $display("FAIL ready_after_reset got %b%b%b want 111", awready, wready, arready);
    end
  endtask

  task automatic test_same_cycle;
    wr(8'h04, 32'hDEADBEEF, 4'hF, 0);
    checks++;
    if (bvalid !== 1'b0) begin errors++; $display("FAIL b_early got %b want 0", bvalid); end
    @(posedge clk); #1;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL b_latency got %b want 1", bvalid); end
    get_b(0);
    rd(8'h04);
    get_r(0);
    rd(8'h07); // misaligned aliases register 1
    get_r(0);
  endtask

  task automatic test_w_first_strb;
    wr(8'h0C, 32'h11223344, 4'hF, 3);
    get_b(2);
    wr(8'h0C, 32'hAABBCCDD, 4'h5, 0);
    get_b(2);
    rd(8'h0C);
    get_r(0);
    checks++;
    if (mem[3] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL strb_model got %h want 11bb33dd", mem[3]);
    end
    wr(8'h0C, 32'hFFFFFFFF, 4'h0, 0);
    get_b(0);
    rd(8'h0C);
    get_r(0);
  endtask

  task automatic test_out_of_range;
    wr(8'h40, 32'hCAFEF00D, 4'hF, 0);
    get_b(0);
    rd(8'h40);
    get_r(0);
    for (int i = 0; i < 16; i++) begin
      rd(8'(4 * i));
      get_r(0);
    end
  endtask

  task automatic test_ro;
    wr(8'h08, 32'h12345678, 4'hF, 0);
    get_b(0);
    rd(8'h08);
    get_r(0);
  endtask

  task automatic test_stall;
    wr(8'h10, 32'h5A5A0F0F, 4'hF, 0);
    get_b(5);
    rd(8'h10);
    get_r(5);
  endtask

  task automatic test_concurrent;
    rq.push_back({2'b00, mem[5]});
    wr(8'h14, 32'h01020304, 4'hF, 0);
    // Now just after the AW/W edge; AR handshakes on the commit edge.
    araddr = 8'h14; arvalid = 1'b1;
    @(posedge clk); #1 arvalid = 1'b0;
    get_b(0);
    get_r(0);
    rd(8'h14);
    get_r(0);
  endtask

  task automatic test_reset_mid;
    send_aw(8'h04);
    rd(8'h04);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata} !== '0) begin
      errors++;
      $display("FAIL async_reset got rdy=%b%b%b bv=%b rv=%b data=%h want all 0",
               awready, wready, arready, bvalid, rvalid, rdata);
    end
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bq.delete();
    rq.delete();
    @(negedge clk);
    reset = 1'b0;
    // A W alone must not commit against a stale buffered AW.
    send_w(32'h77777777, 4'hF);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b0) begin errors++; $display("FAIL stale_aw got bvalid=%b want 0", bvalid); end
    end
    mem[3] = 32'h77777777;
    bq.push_back(2'b00);
    send_aw(8'h0C);
    get_b(0);
    rd(8'h04);
    get_r(0);
    rd(8'h0C);
    get_r(0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_same_cycle();
    test_w_first_strb();
    test_out_of_range();
    test_ro();
    test_stall();
    test_concurrent();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile_strb.md
# axi_lite_regfile_strb

Parametrised AXI4-Lite slave register file, the successor to the 16-entry, 4-bit-address slave in the peripheral subsystem. Adds byte-addressed registers with configurable width and depth, WSTRB byte enables, independent any-order acceptance of AW and W, per-register read-only masking, and SLVERR responses for illegal accesses. It sits behind the system AXI-Lite interconnect as a generic control/status register bank.

## Interface
- ADDR_WIDTH, 8, byte-address width; must hold NUM_REGS*DATA_WIDTH/8 bytes
- DATA_WIDTH, 32, bus and register width; 32 or 64
- NUM_REGS, 16, number of registers, 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8))
- RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only (reads 0 unless otherwise loaded; writes rejected)
- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-high reset
- AWADDR  in  ADDR_WIDTH  write byte address; AWVALID in 1; AWREADY out 1
- WDATA  in  DATA_WIDTH  write data; WSTRB in DATA_WIDTH/8 byte enables; WVALID in 1; WREADY out 1
- BRESP  out  2  write response; BVALID out 1; BREADY in 1
- ARADDR  in  ADDR_WIDTH  read byte address; ARVALID in 1; ARREADY out 1
- RDATA  out  DATA_WIDTH  read data; RRESP out 2; RVALID out 1; RREADY in 1

## Operation
- Register index = ADDR[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]; low byte-offset bits ignored (misaligned treated as aligned).
- Write path: one-entry AW buffer and one-entry W buffer, each filled independently on its handshake, in either order or together.
- Commit: on the first posedge where both buffers are full and BVALID=0: if index < NUM_REGS and RO_MASK[index]=0, update byte k of register where WSTRB[k]=1, BRESP=OKAY(00); else no update, BRESP=SLVERR(10). Same edge: BVALID<=1, both buffers cleared.
- WSTRB all-zero to a legal register: no change, BRESP=OKAY.
- BVALID holds with BRESP stable until BREADY=1 at a posedge.
- Read path: on AR handshake, RDATA<=register[index], RRESP=OKAY; index >= NUM_REGS gives RDATA=0, RRESP=SLVERR. RO registers read normally. RVALID<=1, held with RDATA/RRESP stable until RREADY=1.
- Read and write paths fully independent; may operate in the same cycle.

## Timing
- Reset (asynchronous, immediate): all registers 0, both write buffers empty, BVALID=0, BRESP=00, RVALID=0, RRESP=00, RDATA=0; AWREADY, WREADY, ARREADY forced 0 while reset is high.
- AWREADY = !reset && AW buffer empty && !BVALID (combinational from state; never from AWVALID).
- WREADY = !reset && W buffer empty && !BVALID.
- ARREADY = !reset && !RVALID.
- Write latency: BVALID rises one posedge after the later of the AW/W handshake edges (2 cycles from a same-cycle AW+W handshake). Minimum write cycle with BREADY tied high: 3 clocks.
- Read latency: RVALID rises on the AR handshake edge (visible in the next cycle). Minimum read cycle with RREADY tied high: 2 clocks.
- Read and write commit on the same edge to the same register: read returns the pre-write value.
- Second AW while AW buffer full (W outstanding): AWREADY=0, master stalls; same for W.
- BVALID&&BREADY at a posedge: BVALID<=0; READYs reassert the following cycle.
- Reset mid-transaction: buffered AW/W and pending B/R responses discarded; no partial register update.
- Register contents change only on a commit edge.

## Test plan
- Reset then AW+W same cycle, addr 0x04, data 0xDEADBEEF, WSTRB 0xF; read 0x04 -> BRESP=00 two cycles after handshake; RDATA=0xDEADBEEF, RRESP=00.
- W (0x11223344, WSTRB 0xF) three cycles before AW (addr 0x0C), then second write 0xAABBCCDD with WSTRB 0x5 to 0x0C -> reads back 0x11BB33DD; AWREADY/WREADY stay 0 while BVALID high.
- Write to 0x40 (index 16, out of range) and read 0x40 -> BRESP=10, RRESP=10, RDATA=0; registers 0..15 unchanged.
- RO_MASK=0x0004: write 0x12345678 to 0x08 -> BRESP=10, read 0x08 returns 0, RRESP=00.
- Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and BRESP/RDATA stable, AWREADY/WREADY/ARREADY=0 throughout; release -> one-cycle handshake.
- Assert reset with AW buffered and RVALID pending -> all outputs to reset values immediately; after release, read 0x04 returns 0.
